// File: rtl/nes_dma_pkg.sv
// Shared definitions for the NES sprite (OAM) DMA engine.
package nes_dma_pkg;

   // FSM states; StAlign is only reachable when OAM_DMA_ALIGN_EN is defined.
   typedef enum logic [2:0] {
      StIdle,
      StHalt,
      StAlign,
      StRead,
      StWrite
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR    = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR   = 16'h2004;
   localparam int unsigned DMA_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dma_engine.sv
// Sprite DMA engine: on a CPU write to $4014 it halts the CPU and copies one
// page of CPU-side memory into PPU OAM, one read and one write per byte.
// Optional build macro OAM_DMA_ALIGN_EN: inserts an extra alignment cycle when
// the trigger lands on an odd CPU cycle (514 pause cycles instead of 513).
module oam_dma_engine
   import nes_dma_pkg::*;
#(
   parameter int unsigned DMA_LEN = DMA_LEN_DEFAULT,
   parameter int unsigned IDX_W   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_ce,
   input  logic        reg_wr,
   input  logic [7:0]  reg_din,
   output logic        cpu_pause,
   output logic        busy,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   output logic        oam_wr,
   output logic [7:0]  oam_wdata
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   dma_state_t       r_state, w_state_d;
   logic [7:0]       r_page, w_page_d;
   logic [IDX_W-1:0] r_idx, w_idx_d;
   logic [7:0]       r_data, w_data_d;
   logic             r_busy, w_busy_d;
   logic             r_mem_rd, w_mem_rd_d;
   logic             r_oam_wr, w_oam_wr_d;
   logic [15:0]      r_addr, w_addr_d;
   logic [IDX_W-1:0] w_idx_inc;

`ifdef OAM_DMA_ALIGN_EN
   logic r_parity;
   logic r_align, w_align_d;
`endif

   // Index increment wraps within IDX_W bits so the page byte never changes.
   assign w_idx_inc = r_idx + IDX_ONE;

   assign cpu_pause = r_busy;
   assign busy      = r_busy;
   assign mem_addr  = r_addr;
   assign mem_rd    = r_mem_rd;
   assign oam_wr    = r_oam_wr;
   assign oam_wdata = r_data;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= StIdle;
         r_page   <= 8'h00;
         r_idx    <= '0;
         r_data   <= 8'h00;
         r_busy   <= 1'b0;
         r_mem_rd <= 1'b0;
         r_oam_wr <= 1'b0;
         r_addr   <= 16'h0000;
      end else begin
         r_state  <= w_state_d;
         r_page   <= w_page_d;
         r_idx    <= w_idx_d;
         r_data   <= w_data_d;
         r_busy   <= w_busy_d;
         r_mem_rd <= w_mem_rd_d;
         r_oam_wr <= w_oam_wr_d;
         r_addr   <= w_addr_d;
      end
   end

`ifdef OAM_DMA_ALIGN_EN
   // CPU-cycle parity since reset, plus the parity captured at the trigger.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity <= 1'b0;
         r_align  <= 1'b0;
      end else begin
         r_parity <= r_parity ^ cpu_ce;
         r_align  <= w_align_d;
      end
   end
`endif

   // Next-state and next-output logic; everything advances only on cpu_ce.
   always_comb begin
      w_state_d  = r_state;
      w_page_d   = r_page;
      w_idx_d    = r_idx;
      w_data_d   = r_data;
      w_busy_d   = r_busy;
      w_mem_rd_d = r_mem_rd;
      w_oam_wr_d = r_oam_wr;
      w_addr_d   = r_addr;
`ifdef OAM_DMA_ALIGN_EN
      w_align_d  = r_align;
`endif
      if (cpu_ce) begin
         case (r_state)
            StIdle: begin
               if (reg_wr) begin
                  w_state_d = StHalt;
                  w_page_d  = reg_din;
                  w_idx_d   = '0;
                  w_busy_d  = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                  w_align_d = r_parity;
`endif
               end
            end
            StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
               if (r_align) begin
                  w_state_d = StAlign;
               end else begin
                  w_state_d  = StRead;
                  w_mem_rd_d = 1'b1;
                  w_addr_d   = {r_page, 8'(r_idx)};
               end
`else
               w_state_d  = StRead;
               w_mem_rd_d = 1'b1;
               w_addr_d   = {r_page, 8'(r_idx)};
`endif
            end
            StAlign: begin
               w_state_d  = StRead;
               w_mem_rd_d = 1'b1;
               w_addr_d   = {r_page, 8'(r_idx)};
            end
            StRead: begin
               w_data_d   = mem_rdata;
               w_state_d  = StWrite;
               w_mem_rd_d = 1'b0;
               w_oam_wr_d = 1'b1;
            end
            StWrite: begin
               w_oam_wr_d = 1'b0;
               if (r_idx == LAST_IDX) begin
                  w_state_d = StIdle;
                  w_busy_d  = 1'b0;
               end else begin
                  w_idx_d    = w_idx_inc;
                  w_state_d  = StRead;
                  w_mem_rd_d = 1'b1;
                  w_addr_d   = {r_page, 8'(w_idx_inc)};
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed testbench for oam_dma_engine. Honours OAM_DMA_ALIGN_EN when defined.
module tb_oam_dma_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_ce = 1'b0;
   logic        reg_wr = 1'b0;
   logic [7:0]  reg_din = 8'h00;
   logic        cpu_pause, busy, mem_rd, oam_wr;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata, oam_wdata;

   int checks = 0;
   int errors = 0;

   logic ce_en = 1'b1;
   logic ce_phase = 1'b0;
   int   ce_total = 0;
   int   pause_cnt = 0;
   int   trig_par = 0;
   logic [7:0]  oam_q[$];
   logic [15:0] addr_q[$];

   oam_dma_engine dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_ce    (cpu_ce),
      .reg_wr    (reg_wr),
      .reg_din   (reg_din),
      .cpu_pause (cpu_pause),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .oam_wr    (oam_wr),
      .oam_wdata (oam_wdata)
   );

   // RAM model: page p, offset i holds i ^ p ^ 8'h58 (page $02 gives i ^ 8'h5A).
   assign mem_rdata = mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h58;

   always #5 clk = ~clk;

   // cpu_ce generator (one pulse every 2 clk) and per-CPU-cycle monitor.
   // Outputs are sampled on the falling edge, where they are stable for the
   // rising edge that closes the CPU cycle.
   initial forever begin
      @(negedge clk);
      ce_phase = ~ce_phase;
      cpu_ce   = ce_en & ce_phase;
      if (cpu_ce && reset_n) begin
         if (reg_wr && !busy) trig_par = ce_total % 2;
         if (cpu_pause) pause_cnt++;
         if (oam_wr) oam_q.push_back(oam_wdata);
         if (mem_rd) addr_q.push_back(mem_addr);
         ce_total++;
      end
      if (!reset_n) ce_total = 0;
   end

   function automatic int exp_pause();
`ifdef OAM_DMA_ALIGN_EN
      return 513 + trig_par;
`else
      return 513;
`endif
   endfunction

   task automatic clear_log();
      pause_cnt = 0;
      oam_q.delete();
      addr_q.delete();
   endtask

   // Called just after a rising edge; holds reg_wr across one cpu_ce edge.
   task automatic trigger(input logic [7:0] p);
      reg_wr  = 1'b1;
      reg_din = p;
      do @(posedge clk); while (!cpu_ce);
      #1;
      reg_wr = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bytes(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk);
         #1;
         if (oam_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cpu_pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", cpu_pause); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (oam_wr !== 1'b0) begin errors++; $display("FAIL reset_oam_wr: got %b expected 0", oam_wr); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
      checks++; if (oam_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", oam_wdata); end
      reset_n = 1'b1;
      clear_log();
      repeat (10) @(posedge clk);
      #1;
      checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL idle_no_read: got %0d reads expected 0", addr_q.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      bit ok;
      clear_log();
      trigger(8'h02);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done: busy still %b expected 0", busy); end
      checks++; if (oam_q.size() !== 256) begin errors++; $display("FAIL basic_oam_count: got %0d expected 256", oam_q.size()); end
      checks++; if (addr_q.size() !== 256) begin errors++; $display("FAIL basic_rd_count: got %0d expected 256", addr_q.size()); end
      if (oam_q.size() == 256 && addr_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (oam_q[i] !== (8'(i) ^ 8'h5A)) begin
               errors++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, oam_q[i], 8'(i) ^ 8'h5A);
            end
            checks++;
            if (addr_q[i] !== 16'(16'h0200 + i)) begin
               errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, addr_q[i], 16'(16'h0200 + i));
            end
         end
      end
      checks++; if (pause_cnt !== exp_pause()) begin errors++; $display("FAIL basic_pause: got %0d expected %0d", pause_cnt, exp_pause()); end
      checks++; if (cpu_pause !== 1'b0 || oam_wr !== 1'b0 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL basic_end_strobes: got pause=%b oam_wr=%b mem_rd=%b expected 0/0/0", cpu_pause, oam_wr, mem_rd);
      end
   endtask

   task automatic test_ignore_rewrite();
      bit ok;
      clear_log();
      trigger(8'h02);
      wait_bytes(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_reach100: got %0d bytes expected 100", oam_q.size()); end
      trigger(8'h07);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_done: busy still %b expected 0", busy); end
      checks++; if (addr_q.size() !== 256) begin errors++; $display("FAIL ign_rd_count: got %0d expected 256", addr_q.size()); end
      if (addr_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (addr_q[i] !== 16'(16'h0200 + i)) begin
               errors++; $display("FAIL ign_addr[%0d]: got %h expected %h", i, addr_q[i], 16'(16'h0200 + i));
            end
         end
      end
      checks++; if (pause_cnt !== exp_pause()) begin errors++; $display("FAIL ign_pause: got %0d expected %0d", pause_cnt, exp_pause()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_log();
      trigger(8'h02);
      wait_bytes(37, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_reach37: got %0d bytes expected 37", oam_q.size()); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cpu_pause !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got busy=%b pause=%b expected 0/0", busy, cpu_pause); end
      checks++; if (mem_rd !== 1'b0 || oam_wr !== 1'b0) begin errors++; $display("FAIL rst_async_strobes: got rd=%b wr=%b expected 0/0", mem_rd, oam_wr); end
      checks++; if (mem_addr !== 16'h0000 || oam_wdata !== 8'h00) begin errors++; $display("FAIL rst_async_data: got addr=%h data=%h expected 0000/00", mem_addr, oam_wdata); end
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clear_log();
      trigger(8'h03);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_new_done: busy still %b expected 0", busy); end
      checks++; if (oam_q.size() !== 256 || addr_q.size() !== 256) begin
         errors++; $display("FAIL rst_new_count: got %0d/%0d expected 256/256", oam_q.size(), addr_q.size());
      end
      if (oam_q.size() == 256 && addr_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (oam_q[i] !== (8'(i) ^ 8'h5B) || addr_q[i] !== 16'(16'h0300 + i)) begin
               errors++; $display("FAIL rst_new[%0d]: got %h@%h expected %h@%h", i, oam_q[i], addr_q[i], 8'(i) ^ 8'h5B, 16'(16'h0300 + i));
            end
         end
      end
      checks++; if (pause_cnt !== exp_pause()) begin errors++; $display("FAIL rst_new_pause: got %0d expected %0d", pause_cnt, exp_pause()); end
   endtask

   task automatic test_stall();
      bit ok;
      logic [15:0] hold;
      clear_log();
      trigger(8'h02);
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk);
         #1;
         if (mem_rd && mem_addr == 16'h0232) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok) begin errors++; $display("FAIL stall_reach: got addr %h expected 0232", mem_addr); end
      ce_en = 1'b0;
      hold  = mem_addr;
      repeat (20) @(posedge clk);
      #1;
      checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL stall_rd_hold: got %b expected 1", mem_rd); end
      checks++; if (mem_addr !== 16'h0232) begin errors++; $display("FAIL stall_addr_hold: got %h expected %h", mem_addr, hold); end
      checks++; if (oam_wr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_state: got wr=%b busy=%b expected 0/1", oam_wr, busy); end
      ce_en = 1'b1;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_done: busy still %b expected 0", busy); end
      checks++; if (oam_q.size() !== 256 || addr_q.size() !== 256) begin
         errors++; $display("FAIL stall_count: got %0d/%0d expected 256/256", oam_q.size(), addr_q.size());
      end
      if (oam_q.size() == 256 && addr_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (oam_q[i] !== (8'(i) ^ 8'h5A) || addr_q[i] !== 16'(16'h0200 + i)) begin
               errors++; $display("FAIL stall[%0d]: got %h@%h expected %h@%h", i, oam_q[i], addr_q[i], 8'(i) ^ 8'h5A, 16'(16'h0200 + i));
            end
         end
      end
      checks++; if (pause_cnt !== exp_pause()) begin errors++; $display("FAIL stall_pause: got %0d expected %0d", pause_cnt, exp_pause()); end
   endtask

   // Trigger once on an even and once on an odd CPU cycle; page $FF also
   // exercises index wrap without carry into the page byte.
   task automatic test_parity();
      bit ok;
      int want;
      for (int s = 0; s < 2; s++) begin
         clear_log();
         for (int k = 0; k < 20; k++) begin
            if (ce_total % 2 == s) break;
            @(posedge clk);
            #1;
         end
         trigger(8'hFF);
         wait_done(ok);
`ifdef OAM_DMA_ALIGN_EN
         want = 513 + s;
`else
         want = 513;
`endif
         checks++; if (!ok) begin errors++; $display("FAIL par%0d_done: busy still %b expected 0", s, busy); end
         checks++; if (pause_cnt !== want) begin errors++; $display("FAIL par%0d_pause: got %0d expected %0d", s, pause_cnt, want); end
         checks++; if (addr_q.size() !== 256) begin errors++; $display("FAIL par%0d_count: got %0d expected 256", s, addr_q.size()); end
         if (addr_q.size() == 256) begin
            checks++; if (addr_q[0] !== 16'hFF00 || addr_q[255] !== 16'hFFFF) begin
               errors++; $display("FAIL par%0d_ends: got %h..%h expected FF00..FFFF", s, addr_q[0], addr_q[255]);
            end
         end
         checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL par%0d_no_carry: got %h expected FFFF", s, mem_addr); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_rewrite();
      test_reset_mid();
      test_stall();
      test_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
